// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and helpers for the bit-serial adder.
//   - state_e   : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - cnt_width : bit-counter width for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A counter of $clog2(width) bits reaches width-1; width >= 2 keeps it >= 1 bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Request/result bundle between an operand source and the serial adder.
//   Signals:
//     start  request, sampled by the adder only when it is not busy
//     a, b   WIDTH-bit operands, captured on an accepted start
//     cin    carry-in, captured on an accepted start
//     busy   high while bits are being processed
//     done   one-cycle pulse when sum/cout are valid
//     sum    WIDTH-bit result
//     cout   carry out of the top bit
//   Modports: master = operand source, slave = adder.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/full_adder.sv
// full_adder
//   Single-bit combinational full adder, used as the serial adder's bit slice.
//   Ports:
//     a_i, b_i  operand bits
//     ci_i      carry in
//     s_o       sum bit
//     co_o      carry out
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    always_comb begin
        s_o  = a_i ^ b_i ^ ci_i;
        co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
    end
endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder: sum = (a + b + cin) mod 2^WIDTH, one bit per
//   clock, LSB first. A start accepted at edge E0 processes bits on edges
//   E1..E_WIDTH (busy high for WIDTH cycles), then done pulses for one cycle.
//   sum/cout hold after done until the next accepted start.
//   Ports:
//     clk  sole clock, rising edge
//     rst  synchronous, active-high reset; discards any in-flight operation
//     bus  serial_adder_if.slave (start/a/b/cin in, busy/done/sum/cout out)
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    import serial_adder_pkg::*;

    localparam int unsigned    CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] sum_d;

    full_adder u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .ci_i (carry_q),
        .s_o  (s_bit),
        .co_o (c_bit)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at sum_q[0].
    always_comb begin
        sum_d = {s_bit, sum_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                // DONE accepts a new request exactly like IDLE, so the two share a branch.
                ST_IDLE, ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= sum_d;
                    carry_q <= c_bit;
                    if (cnt_q == LAST) begin
                        cout_q  <= c_bit;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule
